secded_corrector_pipe: RTL and testbench

- Parametrised, pipelined successor to the fixed 32-bit combinational single-error-correcting circuits in the benchmark set.
- Decodes an extended Hamming (SEC-DED) codeword of DATA_W data bits plus CHK_W check bits.
- Corrects single-bit errors and flags double-bit errors.
- Adds a 2-stage valid/ready pipeline with backpressure and saturating error counters; sits between a memory/link read port and its consumer.

---
 rtl/secded_corrector_pipe.sv | 217 +++++++++++++++++++++
 tb/tb_secded_corrector_pipe.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/secded_corrector_pipe.sv
// Pipelined extended-Hamming (SEC-DED) decoder with valid/ready handshake and saturating error counters.
// Optional syndrome log ports/logic are built only when SECDED_SYND_LOG_EN is defined.
module secded_corrector_pipe #(
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned CNT_W  = 16,
  // Smallest P with 2^P >= DATA_W+P+1, resolved for the legal DATA_W range 8..64
  localparam int unsigned P      = (DATA_W <= 11) ? 4 :
                                   (DATA_W <= 26) ? 5 :
                                   (DATA_W <= 57) ? 6 : 7,
  localparam int unsigned CHK_W  = P + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CHK_W-1:0]  in_chk,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_sec,
  output logic              out_ded,
  output logic [CHK_W-1:0]  out_syn,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_sec,
  output logic [CNT_W-1:0]  cnt_ded
`ifdef SECDED_SYND_LOG_EN
  ,
  output logic              log_valid,
  output logic [CHK_W-1:0]  log_syn
`endif
);

  // Codeword position of data bit idx: the idx-th non-power-of-two position starting at 3.
  function automatic int unsigned data_pos(input int unsigned idx);
    int unsigned cnt;
    int unsigned pos;
    cnt = 0;
    pos = 0;
    for (int unsigned q = 3; q < 256; q++) begin
      if ((q & (q - 1)) != 0) begin
        if (cnt == idx) pos = q;
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic logic [DATA_W-1:0] chk_mask(input int unsigned k);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      m[i] = ((data_pos(i) >> k) & 32'd1) != 32'd0;
    end
    return m;
  endfunction

  localparam logic [CHK_W-1:0] LAST_POS = CHK_W'(DATA_W + P);

  logic a1, a2, fire;

  logic [P-1:0]      syn_c;
  logic              pe_c;

  logic              s1_valid_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [P-1:0]      s1_syn_q;
  logic              s1_pe_q;
  logic              s1_en_q;

  logic [DATA_W-1:0] flip_c;
  logic [DATA_W-1:0] data_d;
  logic              sec_d, ded_d;

  logic              s2_valid_q;
  logic [DATA_W-1:0] s2_data_q;
  logic              s2_sec_q, s2_ded_q;
  logic [CHK_W-1:0]  s2_syn_q;

  logic [CNT_W-1:0]  cnt_sec_q, cnt_sec_d;
  logic [CNT_W-1:0]  cnt_ded_q, cnt_ded_d;

  assign a2       = !s2_valid_q || out_ready;
  assign a1       = !s1_valid_q || a2;
  assign in_ready = a1;
  assign fire     = s2_valid_q && out_ready;

  for (genvar k = 0; k < P; k++) begin : g_syn
    localparam logic [DATA_W-1:0] MASK = chk_mask(k);
    assign syn_c[k] = in_chk[k] ^ (^(in_data & MASK));
  end

  assign pe_c = (^in_data) ^ (^in_chk);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_syn_q   <= '0;
      s1_pe_q    <= 1'b0;
      s1_en_q    <= 1'b0;
    end else if (a1) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_data_q <= in_data;
        s1_syn_q  <= syn_c;
        s1_pe_q   <= pe_c;
        s1_en_q   <= en;
      end
    end
  end

  // Syndromes that are powers of two or zero never match a data position, so flip_c stays clear.
  for (genvar i = 0; i < DATA_W; i++) begin : g_flip
    localparam logic [P-1:0] POS = P'(data_pos(i));
    assign flip_c[i] = (s1_syn_q == POS);
  end

  always_comb begin
    data_d = s1_data_q;
    sec_d  = 1'b0;
    ded_d  = 1'b0;
    if (s1_en_q) begin
      if (s1_pe_q) begin
        if ({1'b0, s1_syn_q} <= LAST_POS) begin
          sec_d  = 1'b1;
          data_d = s1_data_q ^ flip_c;
        end else begin
          ded_d = 1'b1;
        end
      end else if (s1_syn_q != '0) begin
        ded_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_sec_q   <= 1'b0;
      s2_ded_q   <= 1'b0;
      s2_syn_q   <= '0;
    end else if (a2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= data_d;
        s2_sec_q  <= sec_d;
        s2_ded_q  <= ded_d;
        s2_syn_q  <= {s1_pe_q, s1_syn_q};
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_sec   = s2_sec_q;
  assign out_ded   = s2_ded_q;
  assign out_syn   = s2_syn_q;

  always_comb begin
    cnt_sec_d = cnt_sec_q;
    cnt_ded_d = cnt_ded_q;
    if (cnt_clr) begin
      cnt_sec_d = '0;
      cnt_ded_d = '0;
    end else if (fire) begin
      if (s2_sec_q && (cnt_sec_q != '1)) cnt_sec_d = cnt_sec_q + 1'b1;
      if (s2_ded_q && (cnt_ded_q != '1)) cnt_ded_d = cnt_ded_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_sec_q <= '0;
      cnt_ded_q <= '0;
    end else begin
      cnt_sec_q <= cnt_sec_d;
      cnt_ded_q <= cnt_ded_d;
    end
  end

  assign cnt_sec = cnt_sec_q;
  assign cnt_ded = cnt_ded_q;

`ifdef SECDED_SYND_LOG_EN
  logic             log_valid_q, log_valid_d;
  logic [CHK_W-1:0] log_syn_q, log_syn_d;

  always_comb begin
    log_valid_d = log_valid_q;
    log_syn_d   = log_syn_q;
    if (cnt_clr) begin
      log_valid_d = 1'b0;
      log_syn_d   = '0;
    end else if (fire && (s2_sec_q || s2_ded_q) && !log_valid_q) begin
      log_valid_d = 1'b1;
      log_syn_d   = s2_syn_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      log_valid_q <= 1'b0;
      log_syn_q   <= '0;
    end else begin
      log_valid_q <= log_valid_d;
      log_syn_q   <= log_syn_d;
    end
  end

  assign log_valid = log_valid_q;
  assign log_syn   = log_syn_q;
`endif

endmodule

// File: tb/tb_secded_corrector_pipe.sv
// Directed bench for secded_corrector_pipe (DATA_W=32, CNT_W=4); log checks only when SECDED_SYND_LOG_EN is defined.
module tb_secded_corrector_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [6:0]  in_chk;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_sec;
  logic        out_ded;
  logic [6:0]  out_syn;
  logic        cnt_clr;
  logic [3:0]  cnt_sec;
  logic [3:0]  cnt_ded;
`ifdef SECDED_SYND_LOG_EN
  logic        log_valid;
  logic [6:0]  log_syn;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  secded_corrector_pipe #(.DATA_W(32), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_chk(in_chk),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sec(out_sec), .out_ded(out_ded), .out_syn(out_syn),
    .cnt_clr(cnt_clr), .cnt_sec(cnt_sec), .cnt_ded(cnt_ded)
`ifdef SECDED_SYND_LOG_EN
    , .log_valid(log_valid), .log_syn(log_syn)
`endif
  );

  // Encoder: XOR the position number of every set data bit into the low check bits.
  function automatic logic [6:0] enc(input logic [31:0] d);
    logic [6:0] c;
    int di;
    c  = '0;
    di = 0;
    for (int pos = 1; pos <= 38; pos++) begin
      if ((pos & (pos - 1)) != 0) begin
        if (d[di]) c[5:0] = c[5:0] ^ 6'(pos);
        di++;
      end
    end
    c[6] = (^d) ^ (^c[5:0]);
    return c;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [6:0] c, input logic e);
    in_valid = 1'b1;
    in_data  = d;
    in_chk   = c;
    en       = e;
    tick();
    in_valid = 1'b0;
  endtask

  // One isolated beat: latency, payload, then counters after delivery.
  task automatic beat(input string tag, input logic [31:0] d, input logic [6:0] c, input logic e,
                      input logic [31:0] xd, input logic xs, input logic xdd, input logic [6:0] xsyn,
                      input logic [3:0] xcs, input logic [3:0] xcd);
    send(d, c, e);
    check({tag, "_lat"}, 64'(out_valid), 64'd0);
    tick();
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_data"}, 64'(out_data), 64'(xd));
    check({tag, "_sec"}, 64'(out_sec), 64'(xs));
    check({tag, "_ded"}, 64'(out_ded), 64'(xdd));
    check({tag, "_syn"}, 64'(out_syn), 64'(xsyn));
    tick();
    check({tag, "_cnt_sec"}, 64'(cnt_sec), 64'(xcs));
    check({tag, "_cnt_ded"}, 64'(cnt_ded), 64'(xcd));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [6:0]  c;
    logic [31:0] b [4];

    rst_n     = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_chk    = '0;
    out_ready = 1'b1;
    cnt_clr   = 1'b0;
    #2;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_cnt_sec", 64'(cnt_sec), 64'd0);
    check("rst_cnt_ded", 64'(cnt_ded), 64'd0);
    #10;
    rst_n = 1'b1;

    d = 32'hDEADBEEF;
    c = enc(d);
    beat("clean",  d,              c,          1'b1, d,              1'b0, 1'b0, 7'h00, 4'd0, 4'd0);
    beat("bit5",   32'hDEADBECF,   c,          1'b1, d,              1'b1, 1'b0, 7'h4A, 4'd1, 4'd0);
`ifdef SECDED_SYND_LOG_EN
    check("log_first_valid", 64'(log_valid), 64'd1);
    check("log_first_syn", 64'(log_syn), 64'h4A);
`endif
    beat("chk6",   d,              c ^ 7'h40,  1'b1, d,              1'b1, 1'b0, 7'h40, 4'd2, 4'd0);
    beat("chk2",   d,              c ^ 7'h04,  1'b1, d,              1'b1, 1'b0, 7'h44, 4'd3, 4'd0);
    beat("bit31",  d ^ 32'h8000_0000, c,       1'b1, d,              1'b1, 1'b0, 7'h66, 4'd4, 4'd0);
    beat("double", 32'hDEADBEEC,   c,          1'b1, 32'hDEADBEEC,   1'b0, 1'b1, 7'h06, 4'd4, 4'd1);
    beat("en_off", 32'hDEADBEEC,   c,          1'b0, 32'hDEADBEEC,   1'b0, 1'b0, 7'h06, 4'd4, 4'd1);
    beat("syn39",  d,              c ^ 7'h67,  1'b1, d,              1'b0, 1'b1, 7'h67, 4'd4, 4'd2);
`ifdef SECDED_SYND_LOG_EN
    check("log_sticky_syn", 64'(log_syn), 64'h4A);
`endif

    // Backpressure: four clean beats against a stalled consumer.
    b[0] = 32'h1111_0001; b[1] = 32'h2222_0002; b[2] = 32'h3333_0003; b[3] = 32'h4444_0004;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    en        = 1'b1;
    in_data   = b[0]; in_chk = enc(b[0]);
    tick();
    check("stall_ready_1beat", 64'(in_ready), 64'd1);
    in_data = b[1]; in_chk = enc(b[1]);
    tick();
    check("stall_ready_2beat", 64'(in_ready), 64'd0);
    check("stall_head_valid", 64'(out_valid), 64'd1);
    in_data = b[2]; in_chk = enc(b[2]);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_ready_held", 64'(in_ready), 64'd0);
      check("stall_data_held", 64'(out_data), 64'(b[0]));
    end
    out_ready = 1'b1;
    #1;
    check("release_ready", 64'(in_ready), 64'd1);
    check("release_b0", 64'(out_data), 64'(b[0]));
    tick();
    check("release_b1", 64'(out_data), 64'(b[1]));
    in_data = b[3]; in_chk = enc(b[3]);
    tick();
    in_valid = 1'b0;
    check("release_b2", 64'(out_data), 64'(b[2]));
    tick();
    check("release_b3", 64'(out_data), 64'(b[3]));
    check("release_b3_valid", 64'(out_valid), 64'd1);
    tick();
    check("release_empty", 64'(out_valid), 64'd0);
    check("release_cnt_sec", 64'(cnt_sec), 64'd4);

    // Saturation of the 4-bit counter.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_cnt_sec", 64'(cnt_sec), 64'd0);
    check("clr_cnt_ded", 64'(cnt_ded), 64'd0);
`ifdef SECDED_SYND_LOG_EN
    check("clr_log_valid", 64'(log_valid), 64'd0);
`endif
    in_valid = 1'b1;
    in_data  = d ^ 32'h1;
    in_chk   = c;
    for (int i = 0; i < 17; i++) tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("sat_cnt_sec", 64'(cnt_sec), 64'd15);
    check("sat_cnt_ded", 64'(cnt_ded), 64'd0);
`ifdef SECDED_SYND_LOG_EN
    check("sat_log_syn", 64'(log_syn), 64'h43);
`endif

    // Clear coinciding with a delivered error beat.
    send(d ^ 32'h1, c, 1'b1);
    tick();
    check("clrhit_sec", 64'(out_sec), 64'd1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clrhit_cnt_sec", 64'(cnt_sec), 64'd0);
    tick();
    check("clrhit_cnt_after", 64'(cnt_sec), 64'd0);
`ifdef SECDED_SYND_LOG_EN
    check("clrhit_log_valid", 64'(log_valid), 64'd0);
`endif

    // Asynchronous reset with two beats in flight.
    send(d ^ 32'h1, c, 1'b1);
    tick(); tick();
    check("pre_rst_cnt_sec", 64'(cnt_sec), 64'd1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = b[0]; in_chk = enc(b[0]);
    tick();
    in_data   = b[1]; in_chk = enc(b[1]);
    tick();
    in_valid = 1'b0;
    check("inflight_valid", 64'(out_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_cnt_sec", 64'(cnt_sec), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_data", 64'(out_data), 64'd0);
    check("arst_out_syn", 64'(out_syn), 64'd0);
    check("arst_out_sec", 64'(out_sec), 64'd0);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    beat("post_rst", d, c, 1'b1, d, 1'b0, 1'b0, 7'h00, 4'd0, 4'd0);
    tick();
    check("post_rst_drained", 64'(out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
